// File: rtl/batrider_palette_arb.sv
// batrider_palette_arb: shares the palette RAM between video lookups and CPU accesses with posted writes
module batrider_palette_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          CLK96,
  input  logic          RESET96_N,
  input  logic          PIXEL_CEN,
  input  logic          ACTIVE,
  input  logic [AW-1:0] PIXEL_IDX,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_DIN,
  output logic          CPU_ACK,
  output logic [DW-1:0] CPU_DOUT,
  output logic [AW-1:0] RAM_ADDR,
  output logic          RAM_WE,
  output logic [DW-1:0] RAM_WDATA,
  input  logic [DW-1:0] RAM_RDATA,
  output logic [14:0]   RGB
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] IDLE = 3'd0, WACK = 3'd1, RWAIT = 3'd2, RISSUE = 3'd3, RDATA = 3'd4;
  logic [2:0] state;
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic [AW-1:0] rd_addr;
  logic vid_tag, act_tag;
  logic empty, full, pop, push, rd_go;
  // slot arbitration: video first, then FIFO drain, then the pending CPU read
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    pop = !PIXEL_CEN && !empty;
    rd_go = !PIXEL_CEN && empty && state == RISSUE;
    push = state == IDLE && CPU_REQ && !CPU_ACK && CPU_WE && !full;
    RAM_ADDR = PIXEL_CEN ? PIXEL_IDX : pop ? fifo_addr[rd_ptr[PW-1:0]] : rd_go ? rd_addr : '0;
    RAM_WE = pop;
    RAM_WDATA = fifo_data[rd_ptr[PW-1:0]];
  end
  // FIFO storage; contents are qualified by the pointers so they need no reset
  always_ff @(posedge CLK96) begin
    if (push) begin
      fifo_addr[wr_ptr[PW-1:0]] <= CPU_ADDR;
      fifo_data[wr_ptr[PW-1:0]] <= CPU_DIN;
    end
  end
  // FIFO pointers, extra MSB distinguishes full from empty
  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end
  // video pipe: tag the RAM return cycle and blank when the display was inactive
  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      vid_tag <= 1'b0;
      act_tag <= 1'b0;
      RGB <= '0;
    end else begin
      vid_tag <= PIXEL_CEN;
      act_tag <= ACTIVE;
      if (vid_tag) RGB <= act_tag ? RAM_RDATA[14:0] : '0;
    end
  end
  // CPU access FSM; reads wait for the FIFO to drain so they see earlier writes
  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      state <= IDLE;
      CPU_ACK <= 1'b0;
      CPU_DOUT <= '0;
      rd_addr <= '0;
    end else begin
      CPU_ACK <= 1'b0;
      case (state)
        IDLE: if (CPU_REQ && !CPU_ACK) begin
          if (!CPU_WE) begin
            rd_addr <= CPU_ADDR;
            state <= RWAIT;
          end else if (!full) state <= WACK;
        end
        WACK: begin
          CPU_ACK <= 1'b1;
          state <= IDLE;
        end
        RWAIT: if (empty) state <= RISSUE;
        RISSUE: if (rd_go) state <= RDATA;
        RDATA: begin
          CPU_DOUT <= RAM_RDATA;
          CPU_ACK <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
